// File: rtl/core_types_pkg.sv
// Shared core types for the issue/writeback tracking logic.
package core_types_pkg;

  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam int unsigned SB_CNT_W      = 2;

  typedef logic [4:0]          reg_idx_t;
  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
  } wb_port_t;

endpackage

// File: rtl/issue_scoreboard_entry.sv
// One saturating up/down outstanding-write counter for a single register.
module scoreboard_entry #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       inc,
  input  logic [1:0]       dec,
  input  logic             flush,
  output logic             busy,
  output logic             sat,
  output logic [CNT_W-1:0] cnt_next,
  output logic             ovf_pulse,
  output logic             unf_pulse
);

  localparam logic signed [CNT_W+1:0] MAX_S = (CNT_W+2)'(2**CNT_W - 1);

  logic        [CNT_W-1:0] cnt;
  logic signed [CNT_W+1:0] sum;

  // Net increment/decrement with clamping; flush overrides all events.
  always_comb begin
    sum       = $signed({2'b00, cnt}) + $signed({{CNT_W{1'b0}}, inc})
              - $signed({{CNT_W{1'b0}}, dec});
    cnt_next  = cnt;
    ovf_pulse = 1'b0;
    unf_pulse = 1'b0;
    if (flush) begin
      cnt_next = '0;
    end else if (sum[CNT_W+1]) begin
      cnt_next  = '0;
      unf_pulse = 1'b1;
    end else if (sum > MAX_S) begin
      cnt_next  = '1;
      ovf_pulse = 1'b1;
    end else begin
      cnt_next = sum[CNT_W-1:0];
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_next;
  end

  assign busy = (cnt != '0);
  assign sat  = (cnt == '1);

endmodule

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard for the dual-issue pipeline: per-register
// outstanding-write counters feeding the hazard unit's RAW checks.
module issue_scoreboard
  import core_types_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_ARCH_REGS,
  parameter int unsigned CNT_W    = SB_CNT_W,
  localparam int unsigned TOT_W   = $clog2(NUM_REGS*(2**CNT_W-1)+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_a_valid,
  input  logic                iss_a_we,
  input  logic [4:0]          iss_a_rd,
  input  logic                iss_b_valid,
  input  logic                iss_b_we,
  input  logic [4:0]          iss_b_rd,
  input  logic                wb_a_valid,
  input  logic [4:0]          wb_a_rd,
  input  logic                wb_b_valid,
  input  logic [4:0]          wb_b_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] scoreboard,
  output logic [NUM_REGS-1:0] sat_mask,
  output logic [TOT_W-1:0]    inflight_cnt,
  output logic                overflow_err,
  output logic                underflow_err
);

  wb_port_t wb_a, wb_b;
  assign wb_a = '{valid: wb_a_valid, rd: wb_a_rd};
  assign wb_b = '{valid: wb_b_valid, rd: wb_b_rd};

  logic [NUM_REGS-1:0] busy_vec, sat_vec, ovf_vec, unf_vec;
  logic [CNT_W-1:0]    cnt_next_arr [NUM_REGS];
  logic [TOT_W-1:0]    total_next;

  // x0 is never tracked.
  assign busy_vec[0]     = 1'b0;
  assign sat_vec[0]      = 1'b0;
  assign ovf_vec[0]      = 1'b0;
  assign unf_vec[0]      = 1'b0;
  assign cnt_next_arr[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    logic hit_a, hit_b, ret_a, ret_b;
    assign hit_a = iss_a_valid & iss_a_we & (iss_a_rd == reg_idx_t'(r));
    assign hit_b = iss_b_valid & iss_b_we & (iss_b_rd == reg_idx_t'(r));
    assign ret_a = wb_a.valid & (wb_a.rd == reg_idx_t'(r));
    assign ret_b = wb_b.valid & (wb_b.rd == reg_idx_t'(r));

    scoreboard_entry #(.CNT_W(CNT_W)) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       ({1'b0, hit_a} + {1'b0, hit_b}),
      .dec       ({1'b0, ret_a} + {1'b0, ret_b}),
      .flush     (flush),
      .busy      (busy_vec[r]),
      .sat       (sat_vec[r]),
      .cnt_next  (cnt_next_arr[r]),
      .ovf_pulse (ovf_vec[r]),
      .unf_pulse (unf_vec[r])
    );
  end

  // Population count of next-state counters, so the registered total
  // lines up with the registered scoreboard bits.
  always_comb begin
    total_next = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      total_next = total_next + TOT_W'(cnt_next_arr[i]);
  end

  // Registered total and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_cnt  <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      inflight_cnt  <= total_next;
      overflow_err  <= overflow_err  | (|ovf_vec);
      underflow_err <= underflow_err | (|unf_vec);
    end
  end

  assign scoreboard = busy_vec;
  assign sat_mask   = sat_vec;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Tracks outstanding register writes for the dual-issue pipeline.
- Produces the 32-bit pending-write vector that the hazard unit consumes for RAW checks on both issue slots.
- Increments a per-register counter when slot A or slot B issues a register-writing instruction, and decrements it when the matching writeback retires.
- Sits between the issue stage (upstream event source) and the hazard unit (consumer). Writeback feeds back into it.

Parameters:
- NUM_REGS, 32: architectural integer registers tracked. Index 0 (x0) is never tracked.
- CNT_W, 2: width of each per-register outstanding-write counter. Max in flight per register = 2**CNT_W-1 = 3.
- TOT_W, $clog2(NUM_REGS*(2**CNT_W-1)+1) = 7: derived localparam, width of total in-flight count.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- iss_a_valid  in  1  slot A issued this cycle
- iss_a_we  in  1  slot A instruction writes rd
- iss_a_rd  in  5  slot A destination
- iss_b_valid  in  1  slot B issued this cycle
- iss_b_we  in  1  slot B instruction writes rd
- iss_b_rd  in  5  slot B destination
- wb_a_valid  in  1  writeback port A retiring a register write
- wb_a_rd  in  5  writeback port A destination
- wb_b_valid  in  1  writeback port B retiring a register write
- wb_b_rd  in  5  writeback port B destination
- flush  in  1  pipeline kill; clears all tracking
- scoreboard  out  NUM_REGS  bit r = register r has at least one pending write
- sat_mask  out  NUM_REGS  bit r = counter r at maximum; issue must not add another write to r
- inflight_cnt  out  TOT_W  sum of all counters
- overflow_err  out  1  sticky: increment attempted on a saturated counter
- underflow_err  out  1  sticky: writeback to a counter at 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - all counters = 0
  - scoreboard, sat_mask and inflight_cnt = 0
  - both error flags = 0
  - Reset mid-operation discards all tracking immediately.
- Per register r (1..NUM_REGS-1), each cycle:
  - inc_r = (iss_a_valid & iss_a_we & iss_a_rd==r) + (iss_b_valid & iss_b_we & iss_b_rd==r), range 0..2
  - dec_r = (wb_a_valid & wb_a_rd==r) + (wb_b_valid & wb_b_rd==r), range 0..2
  - next = cnt_r + inc_r - dec_r, computed at CNT_W+2 bits signed.
- Saturation:
  - next > max: counter = max, overflow_err set.
  - next < 0: counter = 0, underflow_err set.
  - Both errors stay set until reset.
- Simultaneous events net out in the same cycle:
  - issue + writeback to the same r leaves the counter unchanged.
  - Both slots writing the same rd (WAW within the pair) adds 2.
- Register 0: rd==0 events are ignored on every port. cnt_0, scoreboard[0] and sat_mask[0] are always 0. No error flag is raised for rd==0.
- Outputs are registered from the counters; there is no combinational bypass.
  - An issue at edge t is visible on scoreboard after edge t (1-cycle latency).
  - A writeback at edge t clears the bit after edge t, provided the count reaches 0.
  - Same-cycle WB-to-issue forwarding is the bypass network's job, not this block's.
- scoreboard[r] = (cnt_r != 0); sat_mask[r] = (cnt_r == max).
- inflight_cnt is the registered sum of the next-state counters, so it updates in the same cycle as scoreboard.
- flush has priority over all same-cycle issue and writeback events:
  - All counters go to 0 on the next edge. Error flags are unchanged.
  - The pipeline must suppress writebacks of killed instructions. A stray writeback after flush raises underflow_err.
- The iss_*_we qualifier is required. A valid issue with we=0 (store, branch) never touches any counter.

Decomposition:
- core_types_pkg gains:
  - NUM_ARCH_REGS constant
  - reg_idx_t (logic [4:0])
  - sb_cnt_t (logic [CNT_W-1:0])
  - wb_port_t struct {valid, rd}
  - the writeback port pair uses wb_port_t.
- One natural sub-module: scoreboard_entry, one saturating up/down counter taking inc (0..2), dec (0..2) and flush. It outputs busy, sat, ovf_pulse and unf_pulse. It is instantiated NUM_REGS-1 times by generate.
- The top level contains the decoders, the error-flag ORs and the population adder.

Test Plan:
- Reset, then issue A writing x5 in cycle 1 -> scoreboard=0x0000_0020 from cycle 2; wb_a rd=5 in cycle 4 -> scoreboard=0 from cycle 5, inflight_cnt 1->0.
- A and B both write x7 in one cycle, then a single wb x7 -> cnt_7=2 then 1, scoreboard[7] remains 1; a second wb clears it; no error flags.
- Issue x3 on A plus wb x3 on port B in the same cycle, with cnt_3=1 beforehand -> cnt_3 stays 1, scoreboard[3]=1, inflight_cnt unchanged.
- Four issues to x9 with no writeback -> sat_mask[9]=1 after the third; the fourth raises overflow_err and cnt_9 stays 3, inflight_cnt=3.
- Issue rd=0 with we=1 on both slots, plus wb rd=0 -> scoreboard=0, inflight_cnt=0, no errors.
- With x1, x2 and x31 pending, assert flush together with a new issue to x4 -> all outputs 0 next cycle; a subsequent wb x1 sets underflow_err=1. Asserting rst_n low mid-sequence clears everything asynchronously.
